// File: rtl/wb_uart_msg_sender.sv
// wb_uart_msg_sender: Wishbone master that programs a wbuart-compatible UART
// on the first button press, then sends a fixed message string on each later
// press. Bytes are paced either by a fixed gap or, with WB_MSG_TXPOLL_EN
// defined, by polling the UART TX-busy bit between bytes.
module wb_uart_msg_sender #(
    parameter int unsigned BAUD_DIV      = 434,
    parameter int unsigned MSG_LEN       = 10,
    parameter logic [8*MSG_LEN-1:0] MSG  = "\nRAHAB LUG",
    parameter int unsigned SETUP_WAIT    = 50000000,
    parameter int unsigned GAP_CYCLES    = 1500,
    parameter int unsigned REPEAT_CYCLES = 8250000,
    parameter int unsigned ACK_TIMEOUT   = 1023,
    parameter int unsigned TX_BUSY_BIT   = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_button,
    input  logic        i_repeat,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [1:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    // Last count value of each wait; a zero-length wait still takes one cycle.
    localparam int unsigned SW_LAST  = (SETUP_WAIT    > 0) ? SETUP_WAIT    - 1 : 0;
    localparam int unsigned GAP_LAST = (GAP_CYCLES    > 0) ? GAP_CYCLES    - 1 : 0;
    localparam int unsigned RPT_LAST = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam int unsigned ACK_LAST = (ACK_TIMEOUT   > 0) ? ACK_TIMEOUT   - 1 : 0;

    // One wait counter is shared by all the idle states; size it for the longest.
    localparam int unsigned WAIT_MAX0 = (SETUP_WAIT > GAP_CYCLES) ? SETUP_WAIT : GAP_CYCLES;
    localparam int unsigned WAIT_MAX  = (WAIT_MAX0 > REPEAT_CYCLES) ? WAIT_MAX0 : REPEAT_CYCLES;
    localparam int unsigned WAIT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int unsigned ACK_W     = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int unsigned IDX_W     = $clog2(MSG_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SETUP_WAIT,
        S_LOAD,
        S_WRITE,
`ifdef WB_MSG_TXPOLL_EN
        S_POLL,
`else
        S_GAP,
`endif
        S_REPEAT_WAIT
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [WAIT_W-1:0]  wait_cnt, wait_n;
    logic [ACK_W-1:0]   ack_cnt, ack_n;
    logic               bus, bus_n;
    logic               we, we_n;
    logic [1:0]         addr, addr_n;
    logic [31:0]        data, data_n;
    logic               err, err_n;
    logic               setup_done, setup_n;
    logic               done;

    logic               btn_meta, btn_s, btn_d;
    logic               press;
    logic [7:0]         msg_byte;
    logic               unused_rd;

    // Read data is only consulted in the polling build.
    assign unused_rd = &{1'b0, i_wb_data, 32'(TX_BUSY_BIT)};

    assign press    = btn_d & ~btn_s;
    assign msg_byte = MSG[{idx, 3'b000} +: 8];

    assign o_wb_cyc  = bus;
    assign o_wb_stb  = bus;
    assign o_wb_we   = we;
    assign o_wb_sel  = bus ? 4'hF : 4'h0;
    assign o_wb_addr = addr;
    assign o_wb_data = data;
    assign o_busy    = (state != S_IDLE);
    assign o_done    = done;
    assign o_err     = err;

    // Button synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
            btn_d    <= 1'b1;
        end else begin
            btn_meta <= i_button;
            btn_s    <= btn_meta;
            btn_d    <= btn_s;
        end
    end

    // State and bus registers; reset drops the bus immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            wait_cnt   <= '0;
            ack_cnt    <= '0;
            bus        <= 1'b0;
            we         <= 1'b0;
            addr       <= 2'b00;
            data       <= 32'h0;
            err        <= 1'b0;
            setup_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            wait_cnt   <= wait_n;
            ack_cnt    <= ack_n;
            bus        <= bus_n;
            we         <= we_n;
            addr       <= addr_n;
            data       <= data_n;
            err        <= err_n;
            setup_done <= setup_n;
        end
    end

    // Next-state logic: sequencing of setup, byte writes, pacing and repeat.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        wait_n  = wait_cnt;
        ack_n   = ack_cnt;
        bus_n   = bus;
        we_n    = we;
        addr_n  = addr;
        data_n  = data;
        err_n   = err;
        setup_n = setup_done;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (press) begin
                    err_n = 1'b0;
                    if (!setup_done) begin
                        state_n = S_SETUP;
                        bus_n   = 1'b1;
                        we_n    = 1'b1;
                        addr_n  = 2'b00;
                        data_n  = 32'(BAUD_DIV);
                        ack_n   = '0;
                    end else begin
                        state_n = S_LOAD;
                        idx_n   = '0;
                    end
                end
            end
            S_SETUP, S_WRITE: begin
                if (i_wb_ack) begin
                    bus_n  = 1'b0;
                    we_n   = 1'b0;
                    wait_n = '0;
                    if (state == S_SETUP) begin
                        setup_n = 1'b1;
                        state_n = S_SETUP_WAIT;
                    end else begin
                        idx_n   = idx + 1'b1;
`ifdef WB_MSG_TXPOLL_EN
                        state_n = S_POLL;
`else
                        state_n = S_GAP;
`endif
                    end
                end else if (ack_cnt == ACK_W'(ACK_LAST)) begin
                    bus_n   = 1'b0;
                    we_n    = 1'b0;
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    ack_n = ack_cnt + 1'b1;
                end
            end
            S_SETUP_WAIT: begin
                if (wait_cnt == WAIT_W'(SW_LAST))
                    state_n = S_IDLE;
                else
                    wait_n = wait_cnt + 1'b1;
            end
            S_LOAD: begin
                bus_n   = 1'b1;
                we_n    = 1'b1;
                addr_n  = 2'b11;
                data_n  = {24'h0, msg_byte};
                ack_n   = '0;
                state_n = S_WRITE;
            end
`ifdef WB_MSG_TXPOLL_EN
            S_POLL: begin
                // Issue TX-register reads until the transmitter reports idle.
                if (!bus) begin
                    bus_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = 2'b11;
                    ack_n  = '0;
                end else if (i_wb_ack) begin
                    bus_n = 1'b0;
                    if (!i_wb_data[TX_BUSY_BIT]) begin
                        if (idx == IDX_W'(MSG_LEN)) begin
                            done   = 1'b1;
                            wait_n = '0;
                            state_n = i_repeat ? S_REPEAT_WAIT : S_IDLE;
                        end else begin
                            state_n = S_LOAD;
                        end
                    end
                end else if (ack_cnt == ACK_W'(ACK_LAST)) begin
                    bus_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    ack_n = ack_cnt + 1'b1;
                end
            end
`else
            S_GAP: begin
                if (wait_cnt == WAIT_W'(GAP_LAST)) begin
                    if (idx == IDX_W'(MSG_LEN)) begin
                        done    = 1'b1;
                        wait_n  = '0;
                        state_n = i_repeat ? S_REPEAT_WAIT : S_IDLE;
                    end else begin
                        state_n = S_LOAD;
                    end
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
`endif
            S_REPEAT_WAIT: begin
                // A still-held button at the end of the wait counts as a press.
                if (wait_cnt == WAIT_W'(RPT_LAST)) begin
                    if (!btn_s) begin
                        err_n   = 1'b0;
                        idx_n   = '0;
                        state_n = S_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/wb_uart_msg_sender.md
# wb_uart_msg_sender

Parametrised Wishbone master that programs a wbuart-compatible UART and transmits a compile-time message string when a push-button is pressed. It generalises our single-string button-to-UART controller with configurable message length and content, baud divisor, inter-byte pacing, a repeat mode, an ack timeout and status outputs. It sits between board I/O (button) and the wbuart slave.

## Interface

- `BAUD_DIV`, default 434: value written to the UART setup register (addr 2'b00).
- `MSG_LEN`, default 10: number of bytes sent per message, range 1..64.
- `MSG`, default "\nRAHAB LUG" packed as 8*MSG_LEN bits: byte k is `MSG[8k+7:8k]`; byte 0 is sent first.
- `SETUP_WAIT`, default 50000000: idle cycles after the setup write completes.
- `GAP_CYCLES`, default 1500: cycles between an ack and the next byte write.
- `REPEAT_CYCLES`, default 8250000: cycles between message end and the next start in repeat mode.
- `ACK_TIMEOUT`, default 1023: maximum cycles to wait for `i_wb_ack`.
- `TX_BUSY_BIT`, default 12: bit of the TX-register read data that means the transmitter is busy.

Ports:

- `i_clk` in 1: the only clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_button` in 1: asynchronous, active-low push-button.
- `i_repeat` in 1: static mode select; 1 means resend every REPEAT_CYCLES while the button is held.
- `i_wb_ack` in 1: slave ack.
- `i_wb_data` in 32: slave read data.
- `o_wb_cyc` out 1, `o_wb_stb` out 1, `o_wb_we` out 1.
- `o_wb_sel` out 4: always 4'b1111 during a cycle, otherwise 0.
- `o_wb_addr` out 2.
- `o_wb_data` out 32.
- `o_busy` out 1: high from start of setup or message until return to IDLE.
- `o_done` out 1: one-cycle pulse after the last byte is acked.
- `o_err` out 1: sticky; set on ack timeout and cleared at the next accepted press.

## Operation

- `i_button` passes through a two-flop synchroniser, `btn_s`. A press is the falling edge of `btn_s`.
- In repeat mode, a level-low `btn_s` at the end of REPEAT_WAIT also counts as a press.
- Presses while `o_busy` is high are ignored. There is no mid-message restart.
- `setup_done` resets to 0. The first accepted press performs the setup sequence; later presses send the message.

State machine:

- IDLE:
  - Press with `!setup_done` goes to SETUP.
  - Press with `setup_done` goes to LOAD with idx=0.
- SETUP: write addr 2'b00 with data BAUD_DIV, zero-extended.
  - On ack: `setup_done`=1, go to SETUP_WAIT.
- SETUP_WAIT: count SETUP_WAIT cycles, then go to IDLE. The message needs a further press.
- LOAD: drive addr 2'b11, data {24'h0, byte[idx]}, assert cyc/stb/we, go to WRITE.
- WRITE: hold all bus outputs until ack.
  - On ack: deassert cyc/stb/we at the next edge, idx++, go to GAP.
- GAP: wait GAP_CYCLES.
  - If idx==MSG_LEN, pulse `o_done` and go to REPEAT_WAIT if `i_repeat`, else IDLE.
  - Otherwise go to LOAD.
- REPEAT_WAIT: count REPEAT_CYCLES.
  - If `btn_s`==0, go to LOAD with idx=0. Otherwise go to IDLE.
- Timeout: in SETUP or WRITE, an ack counter reaching ACK_TIMEOUT drops cyc/stb/we, sets `o_err`, and goes to IDLE. `setup_done` is unchanged.
- Counter widths: all counters are $clog2(max+1) wide. idx is $clog2(MSG_LEN+1) wide and never exceeds MSG_LEN.

## Timing

- Reset values:
  - all `o_wb_*` = 0; `o_busy`, `o_done`, `o_err` = 0
  - state = IDLE, `setup_done` = 0, synchroniser flops = 1
- Reset asserted mid-cycle drops cyc/stb at once, asynchronously.
- Press to `o_wb_stb`: 3 cycles (2 sync + 1 state), plus 1 more for the LOAD state when sending.
- stb and cyc are always asserted together. Data and address are stable for the whole cycle.
- An ack arriving in the same cycle stb first rises is accepted.
- Byte period = 2 + ack latency + GAP_CYCLES cycles.
- `o_done` is high in exactly one cycle, the GAP-exit cycle of the last byte.

## Configuration

- `WB_MSG_TXPOLL_EN` defined: GAP is replaced by POLL.
  - POLL performs read cycles (we=0) at addr 2'b11 until `i_wb_data[TX_BUSY_BIT]`==0, then proceeds as at GAP exit.
  - Each read is subject to ACK_TIMEOUT.
  - GAP_CYCLES is unused.
- `WB_MSG_TXPOLL_EN` undefined: fixed GAP_CYCLES pacing. No read cycles are ever issued.

## Test plan

- Setup, with a stub slave acking after 2 cycles and SETUP_WAIT=20: first press produces a single write, addr 0, data 434. `setup_done`=1 and state returns to IDLE after 20 cycles.
- Message, with MSG_LEN=10 and GAP_CYCLES=5: second press produces 10 writes to addr 3 with data 0x47,0x55,0x4C,0x20,0x42,0x41,0x48,0x41,0x52,0x0A, then exactly one `o_done` pulse.
- Ignored press: a press while `o_busy` still yields exactly 10 writes and no restart.
- Timeout: with a slave that never acks and ACK_TIMEOUT=16, stb drops after 16 cycles and `o_err`=1. The next press clears `o_err`.
- Repeat: with `i_repeat`=1, button held and REPEAT_CYCLES=30, the message is sent twice, the second 30 cycles after the first `o_done`. Releasing the button stops it.
- Async reset: `i_rst_n` low during WRITE drops cyc/stb/we before the next clock edge. After release, the next press performs setup again.
